// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared constants and helpers for the bomb map write side
package bomb_pkg;
    localparam int MAP_W = 100;

    localparam logic [1:0] CELL_EMPTY   = 2'b00;
    localparam logic [1:0] CELL_FRESH   = 2'b01;
    localparam logic [1:0] CELL_AGE     = 2'b10;
    localparam logic [1:0] CELL_EXPLODE = 2'b11;

    localparam int GRID_MIN = 1;
    localparam int GRID_MAX = 8;

    localparam logic [1:0] GS_PLAYING = 2'd0;
    localparam logic [1:0] GS_A_WINS  = 2'd1;
    localparam logic [1:0] GS_B_WINS  = 2'd2;
    localparam logic [1:0] GS_DRAW    = 2'd3;

    // Flat map index of a cell; callers only use it for in-bounds positions.
    function automatic logic [6:0] cellIdx(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] idx;
        idx = {4'b0, x} * 8'd10 + {4'b0, y};
        return idx[6:0];
    endfunction
endpackage

// File: rtl/bomb_placer_if.sv
// rtl/bomb_placer_if.sv - player drop request / response bundle
interface bomb_placer_if;
    logic [3:0] playerAx, playerAy, playerBx, playerBy;
    logic       dropA, dropB;
    logic [1:0] healthA, healthB;
    logic       o_ackA, o_ackB, o_nackA, o_nackB;

    modport master (
        output playerAx, playerAy, playerBx, playerBy, dropA, dropB, healthA, healthB,
        input  o_ackA, o_ackB, o_nackA, o_nackB
    );
    modport slave (
        input  playerAx, playerAy, playerBx, playerBy, dropA, dropB, healthA, healthB,
        output o_ackA, o_ackB, o_nackA, o_nackB
    );
endinterface

// File: rtl/bomb_slot_tracker.sv
// rtl/bomb_slot_tracker.sv - per-player live bomb slots and count
module bomb_slot_tracker #(
    parameter int MAX_BOMBS = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tick,
    input  logic                         alloc,
    input  logic [6:0]                   allocIdx,
    input  logic [bomb_pkg::MAP_W-1:0]   updMap0,
    input  logic [bomb_pkg::MAP_W-1:0]   updMap1,
    output logic [1:0]                   count,
    output logic                         full
);
    localparam logic [1:0] MAX_CNT = 2'(MAX_BOMBS);

    logic [MAX_BOMBS-1:0] slotValid;
    logic [6:0]           slotIdx [MAX_BOMBS];
    logic [MAX_BOMBS-1:0] slotFree;
    logic [MAX_BOMBS-1:0] allocOneHot;
    logic [1:0]           relCount;

    always_comb begin
        relCount    = '0;
        slotFree    = '0;
        allocOneHot = '0;
        for (int i = 0; i < MAX_BOMBS; i++) begin
            slotFree[i] = slotValid[i] && !updMap0[slotIdx[i]] && !updMap1[slotIdx[i]];
            relCount    = relCount + {1'b0, slotFree[i]};
        end
        // Descending scan so the lowest free slot wins.
        for (int i = MAX_BOMBS - 1; i >= 0; i--) begin
            if (!slotValid[i]) begin
                allocOneHot    = '0;
                allocOneHot[i] = 1'b1;
            end
        end
    end

    assign full = (count >= MAX_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotValid <= '0;
            count     <= '0;
            for (int i = 0; i < MAX_BOMBS; i++) slotIdx[i] <= '0;
        end else if (tick) begin
            slotValid <= slotValid & ~slotFree;
            count     <= count - relCount;
        end else if (alloc && !full) begin
            slotValid <= slotValid | allocOneHot;
            for (int i = 0; i < MAX_BOMBS; i++)
                if (allocOneHot[i]) slotIdx[i] <= allocIdx;
            count <= count + 2'd1;
        end
    end
endmodule

// File: rtl/bomb_placer.sv
// rtl/bomb_placer.sv - turns drop presses into fresh bombs in the registered bomb map
module bomb_placer #(
    parameter int MAX_BOMBS = 2,
    parameter int GRID_MIN  = bomb_pkg::GRID_MIN,
    parameter int GRID_MAX  = bomb_pkg::GRID_MAX
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        bombTick,
    input  logic [bomb_pkg::MAP_W-1:0]  i_updatedBombMap_0,
    input  logic [bomb_pkg::MAP_W-1:0]  i_updatedBombMap_1,
    input  logic [1:0]                  game_state,
    bomb_placer_if.slave                ply,
    output logic [bomb_pkg::MAP_W-1:0]  o_curBombMap_0,
    output logic [bomb_pkg::MAP_W-1:0]  o_curBombMap_1,
    output logic [1:0]                  o_bombCountA,
    output logic [1:0]                  o_bombCountB
);
    import bomb_pkg::*;

    localparam logic [3:0] GMIN = 4'(GRID_MIN);
    localparam logic [3:0] GMAX = 4'(GRID_MAX);

    function automatic logic [MAP_W-1:0] playMask();
        logic [MAP_W-1:0] m;
        m = '0;
        for (int x = GRID_MIN; x <= GRID_MAX; x++)
            for (int y = GRID_MIN; y <= GRID_MAX; y++)
                m[10*x+y] = 1'b1;
        return m;
    endfunction

    localparam logic [MAP_W-1:0] PLAY_MASK = playMask();

    logic [MAP_W-1:0] map0, map1;
    logic             prevA, prevB, pendA, pendB, prioB;
    logic             riseA, riseB, evalA, evalB, inA, inB;
    logic             okA, okB, contested, acceptA, acceptB, fullA, fullB;
    logic [6:0]       idxA, idxB;

    assign riseA = ply.dropA && !prevA;
    assign riseB = ply.dropB && !prevB;
    assign inA   = ply.playerAx >= GMIN && ply.playerAx <= GMAX &&
                   ply.playerAy >= GMIN && ply.playerAy <= GMAX;
    assign inB   = ply.playerBx >= GMIN && ply.playerBx <= GMAX &&
                   ply.playerBy >= GMIN && ply.playerBy <= GMAX;
    assign idxA  = inA ? cellIdx(ply.playerAx, ply.playerAy) : 7'd0;
    assign idxB  = inB ? cellIdx(ply.playerBx, ply.playerBy) : 7'd0;

    // Requests wait out tick cycles so they are judged against the reloaded map.
    assign evalA = pendA && !bombTick;
    assign evalB = pendB && !bombTick;
    assign okA   = evalA && game_state == GS_PLAYING && ply.healthA != 2'd0 && inA &&
                   {map1[idxA], map0[idxA]} == CELL_EMPTY && !fullA;
    assign okB   = evalB && game_state == GS_PLAYING && ply.healthB != 2'd0 && inB &&
                   {map1[idxB], map0[idxB]} == CELL_EMPTY && !fullB;
    assign contested = okA && okB && idxA == idxB;
    assign acceptA   = okA && !(contested && prioB);
    assign acceptB   = okB && !(contested && !prioB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map0        <= '0;
            map1        <= '0;
            prevA       <= 1'b0;
            prevB       <= 1'b0;
            pendA       <= 1'b0;
            pendB       <= 1'b0;
            prioB       <= 1'b0;
            ply.o_ackA  <= 1'b0;
            ply.o_ackB  <= 1'b0;
            ply.o_nackA <= 1'b0;
            ply.o_nackB <= 1'b0;
        end else begin
            prevA       <= ply.dropA;
            prevB       <= ply.dropB;
            ply.o_ackA  <= acceptA;
            ply.o_ackB  <= acceptB;
            ply.o_nackA <= evalA && !acceptA;
            ply.o_nackB <= evalB && !acceptB;
            if (evalA) pendA <= 1'b0;
            else if (riseA) pendA <= 1'b1;
            if (evalB) pendB <= 1'b0;
            else if (riseB) pendB <= 1'b1;
            if (contested) prioB <= !prioB;
            if (bombTick) begin
                map0 <= i_updatedBombMap_0 & PLAY_MASK;
                map1 <= i_updatedBombMap_1 & PLAY_MASK;
            end else begin
                if (acceptA) begin
                    map0[idxA] <= CELL_FRESH[0];
                    map1[idxA] <= CELL_FRESH[1];
                end
                if (acceptB) begin
                    map0[idxB] <= CELL_FRESH[0];
                    map1[idxB] <= CELL_FRESH[1];
                end
            end
        end
    end

    assign o_curBombMap_0 = map0;
    assign o_curBombMap_1 = map1;

    bomb_slot_tracker #(.MAX_BOMBS(MAX_BOMBS)) u_slotsA (
        .clk(clk), .rst_n(rst_n), .tick(bombTick), .alloc(acceptA), .allocIdx(idxA),
        .updMap0(i_updatedBombMap_0), .updMap1(i_updatedBombMap_1),
        .count(o_bombCountA), .full(fullA)
    );

    bomb_slot_tracker #(.MAX_BOMBS(MAX_BOMBS)) u_slotsB (
        .clk(clk), .rst_n(rst_n), .tick(bombTick), .alloc(acceptB), .allocIdx(idxB),
        .updMap0(i_updatedBombMap_0), .updMap1(i_updatedBombMap_1),
        .count(o_bombCountB), .full(fullB)
    );
endmodule

// File: tb/tb_bomb_placer.sv
// tb/tb_bomb_placer.sv - directed self-checking bench for bomb_placer
module tb_bomb_placer;
    logic         clk, rst_n, bombTick;
    logic [99:0]  upd0, upd1, cur0, cur1;
    logic [1:0]   game_state, countA, countB;
    int           checks, errors;

    bomb_placer_if bp();

    bomb_placer #(.MAX_BOMBS(2), .GRID_MIN(1), .GRID_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n), .bombTick(bombTick),
        .i_updatedBombMap_0(upd0), .i_updatedBombMap_1(upd1),
        .game_state(game_state), .ply(bp),
        .o_curBombMap_0(cur0), .o_curBombMap_1(cur1),
        .o_bombCountA(countA), .o_bombCountB(countB)
    );

    always #5 clk = ~clk;

    function automatic logic [99:0] cellBit(input int idx);
        logic [99:0] one;
        one = 100'd1;
        return one << idx;
    endfunction

    task automatic setA(input logic [3:0] x, input logic [3:0] y);
        bp.playerAx = x; bp.playerAy = y;
    endtask

    task automatic setB(input logic [3:0] x, input logic [3:0] y);
        bp.playerBx = x; bp.playerBy = y;
    endtask

    task automatic press(input logic a, input logic b);
        bp.dropA = a; bp.dropB = b;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic lift();
        bp.dropA = 1'b0; bp.dropB = 1'b0;
        @(negedge clk);
    endtask

    task automatic tick(input logic [99:0] m0, input logic [99:0] m1);
        upd0 = m0; upd1 = m1; bombTick = 1'b1;
        @(negedge clk);
        bombTick = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (cur0 !== 100'd0) begin errors++; $display("FAIL reset_map0 got %h exp 0", cur0); end
        checks++; if (cur1 !== 100'd0) begin errors++; $display("FAIL reset_map1 got %h exp 0", cur1); end
        checks++; if (countA !== 2'd0 || countB !== 2'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", countA, countB); end
        checks++; if ({bp.o_ackA, bp.o_ackB, bp.o_nackA, bp.o_nackB} !== 4'b0) begin errors++; $display("FAIL reset_acks got %b exp 0000", {bp.o_ackA, bp.o_ackB, bp.o_nackA, bp.o_nackB}); end
    endtask

    task automatic test_single();
        setA(3, 4);
        press(1, 0);
        checks++; if (bp.o_ackA !== 1'b1 || bp.o_nackA !== 1'b0) begin errors++; $display("FAIL single_ackA got ack=%b nack=%b exp 1/0", bp.o_ackA, bp.o_nackA); end
        checks++; if (bp.o_ackB !== 1'b0 || bp.o_nackB !== 1'b0) begin errors++; $display("FAIL single_B_quiet got ack=%b nack=%b exp 0/0", bp.o_ackB, bp.o_nackB); end
        checks++; if (cur0 !== cellBit(34) || cur1 !== 100'd0) begin errors++; $display("FAIL single_map got %h/%h exp bit34 only", cur1, cur0); end
        checks++; if (countA !== 2'd1) begin errors++; $display("FAIL single_countA got %0d exp 1", countA); end
        lift();
        checks++; if (bp.o_ackA !== 1'b0) begin errors++; $display("FAIL single_ack_pulse got %b exp 0", bp.o_ackA); end
    endtask

    task automatic test_limit();
        setA(3, 5);
        press(1, 0);
        checks++; if (bp.o_ackA !== 1'b1 || countA !== 2'd2) begin errors++; $display("FAIL limit_second got ack=%b cnt=%0d exp 1/2", bp.o_ackA, countA); end
        lift();
        setA(3, 6);
        press(1, 0);
        checks++; if (bp.o_nackA !== 1'b1 || bp.o_ackA !== 1'b0) begin errors++; $display("FAIL limit_third got ack=%b nack=%b exp 0/1", bp.o_ackA, bp.o_nackA); end
        checks++; if (countA !== 2'd2) begin errors++; $display("FAIL limit_count got %0d exp 2", countA); end
        checks++; if (cur0 !== (cellBit(34) | cellBit(35))) begin errors++; $display("FAIL limit_map got %h exp bits 34,35", cur0); end
        lift();
    endtask

    task automatic test_tick_release();
        tick(cellBit(35), 100'd0);
        checks++; if (cur0 !== cellBit(35)) begin errors++; $display("FAIL tick_reload got %h exp bit35", cur0); end
        checks++; if (countA !== 2'd1) begin errors++; $display("FAIL tick_release got %0d exp 1", countA); end
        setA(3, 6);
        press(1, 0);
        checks++; if (bp.o_ackA !== 1'b1 || countA !== 2'd2) begin errors++; $display("FAIL tick_redrop got ack=%b cnt=%0d exp 1/2", bp.o_ackA, countA); end
        checks++; if (cur0 !== (cellBit(35) | cellBit(36))) begin errors++; $display("FAIL tick_redrop_map got %h exp bits 35,36", cur0); end
        lift();
        tick(100'd0, 100'd0);
        checks++; if (countA !== 2'd0 || cur0 !== 100'd0) begin errors++; $display("FAIL tick_clear got cnt=%0d map=%h exp 0/0", countA, cur0); end
    endtask

    task automatic test_contest();
        setA(5, 5); setB(5, 5);
        press(1, 1);
        checks++; if ({bp.o_ackA, bp.o_nackA, bp.o_ackB, bp.o_nackB} !== 4'b1001) begin errors++; $display("FAIL contest1 got %b exp 1001", {bp.o_ackA, bp.o_nackA, bp.o_ackB, bp.o_nackB}); end
        checks++; if (cur0 !== cellBit(55) || countA !== 2'd1 || countB !== 2'd0) begin errors++; $display("FAIL contest1_state got map=%h cnt=%0d/%0d", cur0, countA, countB); end
        lift();
        press(0, 1);
        checks++; if (bp.o_nackB !== 1'b1 || countB !== 2'd0) begin errors++; $display("FAIL occupied got nack=%b cnt=%0d exp 1/0", bp.o_nackB, countB); end
        lift();
        tick(100'd0, 100'd0);
        press(1, 1);
        checks++; if ({bp.o_ackA, bp.o_nackA, bp.o_ackB, bp.o_nackB} !== 4'b0110) begin errors++; $display("FAIL contest2 got %b exp 0110", {bp.o_ackA, bp.o_nackA, bp.o_ackB, bp.o_nackB}); end
        checks++; if (countA !== 2'd0 || countB !== 2'd1 || cur0 !== cellBit(55)) begin errors++; $display("FAIL contest2_state got map=%h cnt=%0d/%0d", cur0, countA, countB); end
        lift();
        tick(100'd0, 100'd0);
        checks++; if (countB !== 2'd0) begin errors++; $display("FAIL contest_clear got %0d exp 0", countB); end
    endtask

    task automatic test_drop_with_tick();
        setA(2, 2);
        upd0 = 100'd0; upd1 = cellBit(77);
        bp.dropA = 1'b1; bombTick = 1'b1;
        @(negedge clk);
        bombTick = 1'b0;
        checks++; if (cur1 !== cellBit(77) || cur0 !== 100'd0 || bp.o_ackA !== 1'b0) begin errors++; $display("FAIL dwt_reload got map=%h/%h ack=%b", cur1, cur0, bp.o_ackA); end
        @(negedge clk);
        checks++; if (bp.o_ackA !== 1'b1 || cur0 !== cellBit(22) || cur1 !== cellBit(77)) begin errors++; $display("FAIL dwt_ack got ack=%b map=%h/%h", bp.o_ackA, cur1, cur0); end
        lift();
        tick(100'd0, 100'd0);
        checks++; if (countA !== 2'd0 || cur1 !== 100'd0) begin errors++; $display("FAIL dwt_clear got cnt=%0d map1=%h", countA, cur1); end
    endtask

    task automatic test_rejects();
        logic [3:0] xs [4] = '{4'd0, 4'd9, 4'd4, 4'd4};
        logic [3:0] ys [4] = '{4'd4, 4'd9, 4'd4, 4'd4};
        logic [1:0] hs [4] = '{2'd3, 2'd3, 2'd0, 2'd3};
        logic [1:0] gs [4] = '{2'd0, 2'd0, 2'd0, 2'd2};
        for (int i = 0; i < 4; i++) begin
            setA(xs[i], ys[i]);
            bp.healthA = hs[i]; game_state = gs[i];
            press(1, 0);
            checks++; if (bp.o_nackA !== 1'b1 || bp.o_ackA !== 1'b0) begin errors++; $display("FAIL reject%0d got ack=%b nack=%b exp 0/1", i, bp.o_ackA, bp.o_nackA); end
            checks++; if (cur0 !== 100'd0 || countA !== 2'd0) begin errors++; $display("FAIL reject%0d_state got map=%h cnt=%0d", i, cur0, countA); end
            lift();
        end
        bp.healthA = 2'd3; game_state = 2'd0;
    endtask

    task automatic test_reset_mid();
        setA(4, 4);
        press(1, 0);
        checks++; if (bp.o_ackA !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b exp 1", bp.o_ackA); end
        lift();
        setA(4, 5);
        bp.dropA = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cur0 !== 100'd0 || cur1 !== 100'd0 || countA !== 2'd0 || countB !== 2'd0) begin errors++; $display("FAIL rmid_clear got map=%h cnt=%0d/%0d", cur0, countA, countB); end
        checks++; if ({bp.o_ackA, bp.o_ackB, bp.o_nackA, bp.o_nackB} !== 4'b0) begin errors++; $display("FAIL rmid_acks got %b exp 0000", {bp.o_ackA, bp.o_ackB, bp.o_nackA, bp.o_nackB}); end
        bp.dropA = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bp.o_ackA !== 1'b0 || bp.o_nackA !== 1'b0 || cur0 !== 100'd0) begin errors++; $display("FAIL rmid_quiet%0d got ack=%b nack=%b map=%h", i, bp.o_ackA, bp.o_nackA, cur0); end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        clk = 1'b0; rst_n = 1'b0; bombTick = 1'b0;
        upd0 = '0; upd1 = '0; game_state = 2'd0;
        bp.dropA = 1'b0; bp.dropB = 1'b0;
        bp.healthA = 2'd3; bp.healthB = 2'd3;
        setA(3, 4); setB(7, 7);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single();
        test_limit();
        test_tick_release();
        test_contest();
        setB(7, 7);
        test_drop_with_tick();
        test_rejects();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bomb_placer.md
Name: bomb_placer

Overview:
- Write side of the bomb map. Turns player drop-bomb button presses into new bombs in the per-cell 2-bit bomb map.
- Owns the registered current map (o_curBombMap_0/1) that the bomb tick/explode block consumes.
- Reloads the map from that block's updated map on every bomb tick.
- Enforces per-player bomb limits, cell occupancy, grid bounds and same-cell arbitration between players.

Parameters:
- MAX_BOMBS, 2, maximum live bombs per player (1..3).
- GRID_MIN, 1, lowest playable x/y coordinate.
- GRID_MAX, 8, highest playable x/y coordinate.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- bombTick  in  1  one-clk strobe, synchronous to clk, issued once per bomb clock period after the updated map is stable.
- i_updatedBombMap_0  in  100  bit 0 of each cell state from the bomb tick block; cell index = 10*x+y.
- i_updatedBombMap_1  in  100  bit 1 of each cell state.
- playerAx, playerAy, playerBx, playerBy  in  4 each  player grid positions.
- dropA, dropB  in  1 each  debounced drop buttons (level).
- healthA, healthB  in  2 each  current player health.
- game_state  in  2  0 = playing, 1/2/3 = game over.
- o_curBombMap_0  out  100  current map, bit 0 per cell.
- o_curBombMap_1  out  100  current map, bit 1 per cell.
- o_bombCountA, o_bombCountB  out  2 each  live bombs owned by each player.
- o_ackA, o_ackB  out  1 each  one-cycle pulse: drop accepted.
- o_nackA, o_nackB  out  1 each  one-cycle pulse: drop rejected.

Behaviour:
- Cell encoding {map_1, map_0}:
  - 00 = empty.
  - 01 = freshly placed.
  - 10, 11 = aging/exploding; these are advanced only by the tick block.
- Reset (rst_n low, asynchronous):
  - both maps = 0; both counts = 0; all ownership slots invalid.
  - all ack/nack = 0; pending flags = 0; arbitration priority = A.
- Request capture:
  - A rising edge of dropX (registered previous value) sets pendingX.
  - Further edges while pendingX is set are ignored.
- Tick cycle (bombTick = 1):
  - o_curBombMap_* <= i_updatedBombMap_* (full replace).
  - Each valid slot whose cell reads 00 in i_updatedBombMap is invalidated, and its owner's count is decremented in the same cycle.
  - Pending requests are held, not evaluated. Latency from tick to freed capacity is 1 clk.
- Non-tick cycle with pendingX set: evaluate the request.
  - Accept only if all of the following hold:
    - game_state == 0;
    - healthX != 0;
    - GRID_MIN <= x,y <= GRID_MAX;
    - the cell in o_curBombMap is 00;
    - countX < MAX_BOMBS.
  - On accept:
    - the cell becomes 01 in the next cycle;
    - the cell index is written to the lowest free slot and countX increments;
    - ackX pulses; pendingX clears.
  - On reject: nackX pulses; pendingX clears; map unchanged.
  - Decision latency from the pending flag to ack/nack is 1 clk.
- Both players pending, same cell, both otherwise acceptable:
  - the priority holder is accepted and the other is nacked;
  - priority toggles after every such contested cycle.
- Both players pending, different cells: both are evaluated and accepted independently in the same cycle.
- A player may re-drop on a cell only after a tick returns it to 00.
- Counts saturate at MAX_BOMBS; no underflow (release only applies to valid slots).
- Map bits outside the 8x8 playable interior are always 0 on output.
- Reset asserted mid-operation clears everything immediately, including requests pending at that time; no ack or nack is issued for them.

Decomposition:
- Shared package bomb_pkg:
  - MAP_W = 100;
  - cell state constants CELL_EMPTY, CELL_FRESH, CELL_AGE, CELL_EXPLODE;
  - GRID_MIN, GRID_MAX;
  - a cell-index function 10*x+y;
  - game_state encodings.
- Sub-module bomb_slot_tracker, instantiated once per player. It holds MAX_BOMBS {valid, 7-bit index} slots and the count, and provides:
  - allocate strobe;
  - release-scan against the updated map on tick;
  - full flag.

Test Plan:
- Reset, then A at (3,4) pulses dropA -> ackA; cell 34 = 01 next clk; countA = 1; no other cells are set.
- A drops at (3,4), (3,5) then (3,6) with MAX_BOMBS = 2 -> ack, ack, nack; countA stays 2.
- Tick with updated cell 34 = 00 -> countA goes to 1 one cycle after the tick; a new drop at (3,6) is then acked.
- A and B both at (5,5) drop in the same cycle, twice (cell cleared between attempts) -> first: ackA/nackB; second: ackB/nackA.
- Drop asserted in the same cycle as bombTick -> map reloads first; ack follows 1 clk later with cell = 01.
- Drop at (0,4) or (9,9), with healthA = 0 or game_state = 2 -> nack; map unchanged; rst_n low mid-pending -> no ack/nack; all outputs 0.
